board_scanner: RTL

Sequential status evaluator for the 4x4 2048 board. It reads the packed cell matrix that the reset/initialisation and move logic write, and walks it one cell per clock. At the end of the walk it reports the empty-cell mask and count, the largest tile, the win flag and the game-over flag. The game-control FSM uses these results to pick a spawn location for a random tile and to decide whether the game has ended.

---
 rtl/board_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/board_scanner.sv
// board_scanner
// Walks a 4x4 2048 board one cell per clock and reports the empty-cell mask
// and count, the largest tile exponent, and the win and game-over flags.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           scan request, only honoured while idle
//   cell_matrix_in  board, cell i at row i/4, column i%4, 0 = empty, n = 2^n
//   busy            high from the accepted start until the done pulse ends
//   done            one-cycle pulse when the result outputs are fresh
//   empty_mask      bit i set when cell i is empty
//   empty_count     number of empty cells (0..16)
//   max_tile        largest exponent on the board
//   win             max_tile >= WIN_EXP
//   game_over       board full and no equal non-zero neighbours
module board_scanner #(
    parameter int WIN_EXP = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0][3:0] cell_matrix_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      empty_mask,
    output logic [4:0]       empty_count,
    output logic [3:0]       max_tile,
    output logic             win,
    output logic             game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0][3:0] snap;
    logic [3:0]       idx;
    logic [15:0]      mask_acc;
    logic [4:0]       count_acc;
    logic [3:0]       max_acc;
    logic             merge_acc;

    logic [3:0] cur;
    logic [3:0] idx_right;
    logic [3:0] idx_down;
    logic       merge_hit;

    // Neighbour indices may wrap for the last column/row; the col/row guards
    // below keep those wrapped reads from ever counting.
    assign cur       = snap[idx];
    assign idx_right = idx + 4'd1;
    assign idx_down  = idx + 4'd4;
    assign merge_hit = (cur != 4'd0) &&
                       (((idx[1:0] != 2'd3) && (snap[idx_right] == cur)) ||
                        ((idx[3:2] != 2'd3) && (snap[idx_down]  == cur)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (idx == 4'd15) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy and done are registered, so both trail the state by one cycle:
    // done appears with the loaded results, and busy covers the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            snap        <= '0;
            idx         <= '0;
            mask_acc    <= '0;
            count_acc   <= '0;
            max_acc     <= '0;
            merge_acc   <= 1'b0;
            empty_mask  <= '0;
            empty_count <= '0;
            max_tile    <= '0;
            win         <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            busy <= (state_q != IDLE) || start;
            done <= (state_q == REPORT);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap      <= cell_matrix_in;
                        idx       <= '0;
                        mask_acc  <= '0;
                        count_acc <= '0;
                        max_acc   <= '0;
                        merge_acc <= 1'b0;
                    end
                end
                SCAN: begin
                    if (cur == 4'd0) begin
                        mask_acc[idx] <= 1'b1;
                        count_acc     <= count_acc + 5'd1;
                    end
                    if (cur > max_acc) max_acc <= cur;
                    if (merge_hit) merge_acc <= 1'b1;
                    if (idx != 4'd15) idx <= idx + 4'd1;
                end
                REPORT: begin
                    empty_mask  <= mask_acc;
                    empty_count <= count_acc;
                    max_tile    <= max_acc;
                    win         <= (max_acc >= 4'(WIN_EXP));
                    game_over   <= (count_acc == 5'd0) && !merge_acc;
                end
                default: ;
            endcase
        end
    end

endmodule
